// File: rtl/vga_pkg.sv
// Shared video timing and colour constants for the vga_if pipeline (800x600@60, 40 MHz pixel clock).
// Defaults only; each stage may override its own parameters.
package vga_pkg;

    localparam int CNT_W = 11;

    localparam int HOR_ACTIVE = 800;
    localparam int HOR_FP     = 40;
    localparam int HOR_SYNC   = 128;
    localparam int HOR_BP     = 88;
    localparam int HOR_TOTAL  = HOR_ACTIVE + HOR_FP + HOR_SYNC + HOR_BP;

    localparam int VER_ACTIVE = 600;
    localparam int VER_FP     = 1;
    localparam int VER_SYNC   = 4;
    localparam int VER_BP     = 23;
    localparam int VER_TOTAL  = VER_ACTIVE + VER_FP + VER_SYNC + VER_BP;

    localparam logic SYNC_POL = 1'b1;

    localparam logic [11:0] BLACK         = 12'h000;
    localparam logic [11:0] GAME_BG_COLOR = 12'h8_A_F;

endpackage

// File: rtl/vga_if.sv
// Raster bundle forwarded stage to stage along the video chain.
// Every field describes the same pixel in the same cycle.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_wrap_counter.sv
// Modulo-(MAX+1) counter: advances on en, wraps MAX->0, wrap flags the advancing edge at MAX.
// Zero latency on count_nxt/wrap; holds when en is low; clr overrides en.
module vga_wrap_counter
    import vga_pkg::*;
#(
    parameter int MAX = HOR_TOTAL - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nxt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign wrap = en && (count_q == MAX_C);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign count_nxt = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Head of the video chain: hcount/vcount raster with sync/blank strobes, rgb forced to 0, frame_start tick.
// Strobes are decoded from next counts into the counter flop stage (zero latency); en low freezes everything.
module vga_timing_gen #(
    parameter int   H_ACTIVE = vga_pkg::HOR_ACTIVE,
    parameter int   H_FP     = vga_pkg::HOR_FP,
    parameter int   H_SYNC   = vga_pkg::HOR_SYNC,
    parameter int   H_BP     = vga_pkg::HOR_BP,
    parameter int   V_ACTIVE = vga_pkg::VER_ACTIVE,
    parameter int   V_FP     = vga_pkg::VER_FP,
    parameter int   V_SYNC   = vga_pkg::VER_SYNC,
    parameter int   V_BP     = vga_pkg::VER_BP,
    parameter logic SYNC_POL = vga_pkg::SYNC_POL
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    vga_if.out    out,
    output logic  frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT_C  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_ON_C  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_OFF_C = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_C  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_ON_C  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_OFF_C = 11'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 2047 || V_TOTAL > 2047 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
        $fatal(1, "vga_timing_gen: illegal timing parameters");
    end

    logic [10:0] h_cnt, h_nxt, v_cnt, v_nxt;
    logic        h_wrap, v_wrap;

    vga_wrap_counter #(.MAX(H_TOTAL - 1)) u_hcnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (1'b0),
        .count     (h_cnt),
        .count_nxt (h_nxt),
        .wrap      (h_wrap)
    );

    // v_nxt equals v_cnt except on an h wrap, so vsync can only move with hcount -> 0.
    vga_wrap_counter #(.MAX(V_TOTAL - 1)) u_vcnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en & h_wrap),
        .clr       (1'b0),
        .count     (v_cnt),
        .count_nxt (v_nxt),
        .wrap      (v_wrap)
    );

    logic hsync_q, vsync_q, hblnk_q, vblnk_q, fstart_q;
    logic hsync_d, vsync_d, hblnk_d, vblnk_d, fstart_d;

    always_comb begin
        hblnk_d  = (h_nxt >= H_ACT_C);
        vblnk_d  = (v_nxt >= V_ACT_C);
        hsync_d  = ((h_nxt >= HS_ON_C) && (h_nxt < HS_OFF_C)) ? SYNC_POL : ~SYNC_POL;
        vsync_d  = ((v_nxt >= VS_ON_C) && (v_nxt < VS_OFF_C)) ? SYNC_POL : ~SYNC_POL;
        fstart_d = v_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q  <= ~SYNC_POL;
            vsync_q  <= ~SYNC_POL;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            if (en) begin
                hsync_q <= hsync_d;
                vsync_q <= vsync_d;
                hblnk_q <= hblnk_d;
                vblnk_q <= vblnk_d;
            end
            fstart_q <= fstart_d;
        end
    end

    assign out.hcount  = h_cnt;
    assign out.vcount  = v_cnt;
    assign out.hsync   = hsync_q;
    assign out.vsync   = vsync_q;
    assign out.hblnk   = hblnk_q;
    assign out.vblnk   = vblnk_q;
    assign out.rgb     = 12'h000;
    assign frame_start = fstart_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default horizontal timing, vertical shortened to 10/1/4/3
// (V_TOTAL 18, 19008 clocks per frame) so two full frames fit a short run.
module tb_vga_timing_gen;

    localparam int HT    = 1056;
    localparam int VT    = 18;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic frame_start;

    vga_if vif();

    vga_timing_gen #(
        .V_ACTIVE (10),
        .V_FP     (1),
        .V_SYNC   (4),
        .V_BP     (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .out         (vif),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_checks++;
        assert (obs === exp_val) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_val);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_hcount"}, 32'(vif.hcount), 0);
        check({tag, "_vcount"}, 32'(vif.vcount), 0);
        check({tag, "_hsync"},  32'(vif.hsync),  0);
        check({tag, "_vsync"},  32'(vif.vsync),  0);
        check({tag, "_hblnk"},  32'(vif.hblnk),  0);
        check({tag, "_vblnk"},  32'(vif.vblnk),  0);
        check({tag, "_rgb"},    32'(vif.rgb),    0);
        check({tag, "_fstart"}, 32'(frame_start), 0);
    endtask

    initial begin
        int errs, hs_cnt, hs_first, hs_last, hb_rise;
        int exp_h, exp_v, vs_cnt, vs_edges, edge_err, pulses, last_pulse, interval, dbl;
        logic prev_hb, prev_vs, prev_fs;

        // ---- reset held 5 clocks with en high ----
        rst_n = 1'b0;
        en    = 1'b1;
        step(5);
        check_reset_values("rst");

        rst_n = 1'b1;
        check("rel_hcount_before_edge", 32'(vif.hcount), 0);
        step(1);
        check("rel_first_hcount", 32'(vif.hcount), 1);
        check("rel_first_fstart", 32'(frame_start), 0);

        // ---- one line: hblnk at 800, hsync 840..967, wrap to (0,1) ----
        errs = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; hb_rise = -1; prev_hb = 1'b0;
        for (int h = 1; h < HT; h++) begin
            if (vif.hcount !== 11'(h) || vif.vcount !== 11'd0 ||
                vif.hblnk !== (h >= 800) || vif.hsync !== (h >= 840 && h < 968) ||
                vif.rgb !== 12'd0 || frame_start !== 1'b0)
                errs++;
            if (vif.hsync === 1'b1) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(vif.hcount);
                hs_last = int'(vif.hcount);
            end
            if (vif.hblnk === 1'b1 && !prev_hb) hb_rise = int'(vif.hcount);
            prev_hb = vif.hblnk;
            step(1);
        end
        check("line_errs", 32'(errs), 0);
        check("hblnk_rise_at", 32'(hb_rise), 800);
        check("hsync_first", 32'(hs_first), 840);
        check("hsync_last", 32'(hs_last), 967);
        check("hsync_width", 32'(hs_cnt), 128);
        check("hwrap_hcount", 32'(vif.hcount), 0);
        check("hwrap_vcount", 32'(vif.vcount), 1);
        check("hwrap_hblnk", 32'(vif.hblnk), 0);

        // ---- run into and through two full frames from (0,1) ----
        errs = 0; exp_h = 0; exp_v = 1; vs_cnt = 0; vs_edges = 0; edge_err = 0;
        pulses = 0; last_pulse = -1; interval = -1; dbl = 0;
        prev_vs = vif.vsync; prev_fs = frame_start;
        for (int c = 1; c <= (VT - 1) * HT + FRAME; c++) begin
            step(1);
            if (exp_h == HT - 1) begin
                exp_h = 0;
                exp_v = (exp_v == VT - 1) ? 0 : exp_v + 1;
            end else begin
                exp_h = exp_h + 1;
            end
            if (vif.hcount !== 11'(exp_h) || vif.vcount !== 11'(exp_v) ||
                vif.vblnk !== (exp_v >= 10) || vif.vsync !== (exp_v >= 11 && exp_v < 15) ||
                frame_start !== (exp_h == 0 && exp_v == 0))
                errs++;
            if (vif.vsync === 1'b1) vs_cnt++;
            if (vif.vsync !== prev_vs) begin
                vs_edges++;
                if (vif.hcount !== 11'd0) edge_err++;
            end
            if (frame_start === 1'b1) begin
                pulses++;
                if (last_pulse >= 0) interval = c - last_pulse;
                last_pulse = c;
                if (prev_fs === 1'b1) dbl++;
            end
            prev_vs = vif.vsync;
            prev_fs = frame_start;
        end
        check("frame_errs", 32'(errs), 0);
        check("vsync_cycles", 32'(vs_cnt), 2 * 4 * HT);
        check("vsync_edges", 32'(vs_edges), 4);
        check("vsync_edge_not_h0", 32'(edge_err), 0);
        check("fstart_pulses", 32'(pulses), 2);
        check("fstart_interval", 32'(interval), FRAME);
        check("fstart_double", 32'(dbl), 0);
        check("frame_end_fstart", 32'(frame_start), 1);
        check("frame_end_vcount", 32'(vif.vcount), 0);

        // ---- en stall at hcount 839 ----
        step(839);
        check("pre_stall_hcount", 32'(vif.hcount), 839);
        check("pre_stall_hsync", 32'(vif.hsync), 0);
        en = 1'b0;
        errs = 0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            if (vif.hcount !== 11'd839 || vif.vcount !== 11'd0 || vif.hsync !== 1'b0 ||
                vif.vsync !== 1'b0 || vif.hblnk !== 1'b1 || vif.vblnk !== 1'b0 ||
                frame_start !== 1'b0)
                errs++;
        end
        check("stall_frozen_errs", 32'(errs), 0);
        en = 1'b1;
        step(1);
        check("resume_hcount", 32'(vif.hcount), 840);
        check("resume_hsync", 32'(vif.hsync), 1);

        // ---- async reset mid-frame at (500,5) ----
        step((HT - 840) + 4 * HT + 500);
        check("pre_arst_hcount", 32'(vif.hcount), 500);
        check("pre_arst_vcount", 32'(vif.vcount), 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("arst");
        step(2);
        check_reset_values("arst_hold");
        rst_n = 1'b1;
        #1;
        check("arst_rel_fstart", 32'(frame_start), 0);
        step(1);
        check("arst_restart_hcount", 32'(vif.hcount), 1);
        check("arst_restart_vcount", 32'(vif.vcount), 0);
        check("arst_restart_fstart", 32'(frame_start), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
